// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: frames VSYNC/HREF timing around a 16-bit pixel
// stream and serialises each pixel as two bytes (high byte first) on an 8-bit bus.
module ov5640_dvp_tx #(
    parameter int H_ACTIVE   = 4,
    parameter int V_ACTIVE   = 2,
    parameter int VSYNC_CYC  = 100,
    parameter int VBP_CYC    = 50,
    parameter int HBLANK_CYC = 10,
    parameter int VFP_CYC    = 200
) (
    input  logic        ov5640_pclk,
    input  logic        sys_rst_n,
    input  logic        tx_en,
    input  logic [15:0] s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        ov5640_vsync,
    output logic        ov5640_href,
    output logic [7:0]  ov5640_data,
    output logic [7:0]  frame_cnt,
    output logic        frame_done,
    output logic        underflow,
    output logic [2:0]  fsm_state_o
);
    localparam int CNT_MAX_A = (VSYNC_CYC > VBP_CYC) ? VSYNC_CYC : VBP_CYC;
    localparam int CNT_MAX_B = (HBLANK_CYC > VFP_CYC) ? HBLANK_CYC : VFP_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BYTE_W    = $clog2(2 * H_ACTIVE + 1);
    localparam int LINE_W    = $clog2(V_ACTIVE + 1);

    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VSYNC_CYC - 1);
    localparam logic [CNT_W-1:0]  VBP_LAST  = CNT_W'(VBP_CYC - 1);
    localparam logic [CNT_W-1:0]  HBL_LAST  = CNT_W'(HBLANK_CYC - 1);
    localparam logic [CNT_W-1:0]  VFP_LAST  = CNT_W'(VFP_CYC - 1);
    localparam logic [CNT_W-1:0]  VFP_PRE   = CNT_W'((VFP_CYC >= 2) ? VFP_CYC - 2 : 0);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(2 * H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BYTE_W-1:0]  byte_q;
    logic [LINE_W-1:0]  line_q;
    logic [7:0]         lo_q;
    logic               vsync_q;
    logic               href_q;
    logic [7:0]         data_q;
    logic [7:0]         frame_cnt_q;
    logic               frame_done_q;
    logic               underflow_q;
    logic [7:0]         hi_byte;

    // A starved fetch still consumes its two byte slots, just with zeros.
    assign hi_byte = s_valid ? s_pixel[15:8] : 8'h00;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_VBP:    s_ready = (cnt_q == VBP_LAST);
            ST_HBLANK: s_ready = (cnt_q == HBL_LAST);
            ST_LINE:   s_ready = byte_q[0] && (byte_q != BYTE_LAST);
            default:   s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            byte_q       <= '0;
            line_q       <= '0;
            lo_q         <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_cnt_q  <= 8'h00;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (s_ready) begin
                lo_q <= s_valid ? s_pixel[7:0] : 8'h00;
                if (!s_valid) underflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    line_q <= '0;
                    if (tx_en) begin
                        state_q <= ST_VSYNC;
                        vsync_q <= 1'b1;
                    end
                end
                ST_VSYNC: begin
                    if (cnt_q == VS_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_VBP;
                        vsync_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_VBP: begin
                    if (cnt_q == VBP_LAST) begin
                        cnt_q   <= '0;
                        byte_q  <= '0;
                        line_q  <= '0;
                        state_q <= ST_LINE;
                        href_q  <= 1'b1;
                        data_q  <= hi_byte;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LINE: begin
                    if (byte_q == BYTE_LAST) begin
                        byte_q <= '0;
                        cnt_q  <= '0;
                        href_q <= 1'b0;
                        data_q <= 8'h00;
                        if (line_q == LINE_LAST) begin
                            state_q <= ST_VFP;
                            // With a one-cycle front porch that cycle is already the last one.
                            if (VFP_CYC == 1) begin
                                frame_done_q <= 1'b1;
                                frame_cnt_q  <= frame_cnt_q + 8'd1;
                            end
                        end else begin
                            state_q <= ST_HBLANK;
                            line_q  <= line_q + LINE_W'(1);
                        end
                    end else begin
                        byte_q <= byte_q + BYTE_W'(1);
                        data_q <= byte_q[0] ? hi_byte : lo_q;
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == HBL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_LINE;
                        href_q  <= 1'b1;
                        data_q  <= hi_byte;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_VFP: begin
                    if (cnt_q == VFP_LAST) begin
                        cnt_q <= '0;
                        if (tx_en) begin
                            state_q <= ST_VSYNC;
                            vsync_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == VFP_PRE) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ov5640_vsync = vsync_q;
    assign ov5640_href  = href_q;
    assign ov5640_data  = data_q;
    assign frame_cnt    = frame_cnt_q;
    assign frame_done   = frame_done_q;
    assign underflow    = underflow_q;
    assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Bench for ov5640_dvp_tx: a frame-position model predicts every output each cycle,
// a pixel queue checks the byte stream end to end, and literal checks pin the timing.
module tb_ov5640_dvp_tx;
  localparam int H = 4, V = 2, VS = 100, VBP = 50, HB = 10, VFP = 200;
  localparam int LINE_P = 2 * H + HB;
  localparam int FRAME = VS + VBP + V * 2 * H + (V - 1) * HB + VFP;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sys_rst_n, tx_en, s_valid, s_ready;
  logic [15:0] s_pixel;
  logic ov5640_vsync, ov5640_href, frame_done, underflow;
  logic [7:0] ov5640_data, frame_cnt;
  logic [2:0] fsm_state;

  ov5640_dvp_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_CYC(VS), .VBP_CYC(VBP),
                  .HBLANK_CYC(HB), .VFP_CYC(VFP)) dut (
    .ov5640_pclk(clk), .sys_rst_n(sys_rst_n), .tx_en(tx_en), .s_pixel(s_pixel),
    .s_valid(s_valid), .s_ready(s_ready), .ov5640_vsync(ov5640_vsync),
    .ov5640_href(ov5640_href), .ov5640_data(ov5640_data), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .underflow(underflow), .fsm_state_o(fsm_state)
  );

  int n_cmp = 0, n_fail = 0;
  logic [15:0] exp_q[$];

  // model state: position inside the current frame
  bit m_in;
  int m_t, m_frames, m_fetch;
  bit m_under;
  logic [15:0] m_cap;

  // stimulus controls
  logic [15:0] dir1[8] = '{16'hA050, 16'hA151, 16'hA252, 16'hA353,
                           16'hB060, 16'hB161, 16'hB262, 16'hB363};
  logic [15:0] dir2[8] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788,
                           16'h99AA, 16'hBBCC, 16'hDDEE, 16'hF001};
  logic [7:0] exp1[16] = '{8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53,
                           8'hB0, 8'h60, 8'hB1, 8'h61, 8'hB2, 8'h62, 8'hB3, 8'h63};
  logic [7:0] exp2[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h77, 8'h88};
  logic [15:0] dir_cur[8];
  int dir_n = 0, valid_pct = 100;
  bit ufl_mode = 0;

  // monitor / capture
  int cyc = 0;
  bit pv, ph, first_line;
  int vs_rise_cyc, vs_fall_cyc, href_rise_cyc, href_fall_cyc, last_done_cyc;
  int last_vs_w, last_vbp, last_gap, last_period, href_min, href_max, done_cnt, vs_rises;
  logic [7:0] cap_b[16];
  int cap_n;
  bit cap_en;
  logic [7:0] rx_hi;
  bit rx_phase;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit f_href(int t);
    int u;
    u = t - (VS + VBP);
    if (u < 0) return 1'b0;
    if (u / LINE_P >= V) return 1'b0;
    return (u % LINE_P) < 2 * H;
  endfunction

  function automatic int f_k(int t);
    return (t - VS - VBP) % LINE_P;
  endfunction

  // A pixel is fetched in the cycle right before its high byte appears.
  function automatic bit f_ready(int t);
    return (t + 1 < FRAME) && f_href(t + 1) && (f_k(t + 1) % 2 == 0);
  endfunction

  function automatic void model_reset();
    m_in = 0; m_t = 0; m_frames = 0; m_fetch = 0; m_under = 0; m_cap = '0;
    exp_q.delete();
    rx_phase = 0;
  endfunction

  function automatic void mon_reset();
    pv = 0; ph = 0; first_line = 0; done_cnt = 0; vs_rises = 0;
    href_min = 9999; href_max = 0; last_vs_w = -1; last_vbp = -1; last_gap = -1; last_period = -1;
  endfunction

  function automatic void model_advance();
    if (m_in) begin
      if (f_ready(m_t)) begin
        m_cap = s_valid ? s_pixel : 16'h0000;
        if (!s_valid) m_under = 1;
        exp_q.push_back(m_cap);
        m_fetch++;
      end
      if (m_t == FRAME - 1) begin
        if (tx_en) begin m_t = 0; m_fetch = 0; end
        else m_in = 0;
      end else begin
        m_t++;
        if (m_t == FRAME - 1) m_frames = (m_frames + 1) % 256;
      end
    end else if (tx_en) begin
      m_in = 1; m_t = 0; m_fetch = 0;
    end
  endfunction

  function automatic void check_outputs();
    bit e_vs, e_hr, e_done, e_rdy;
    logic [7:0] e_data;
    int w;
    e_vs = m_in && (m_t < VS);
    e_hr = m_in && f_href(m_t);
    e_done = m_in && (m_t == FRAME - 1);
    e_rdy = m_in && f_ready(m_t);
    e_data = !e_hr ? 8'h00 : ((f_k(m_t) % 2 == 0) ? m_cap[15:8] : m_cap[7:0]);
    chk("vsync", ov5640_vsync, e_vs);
    chk("href", ov5640_href, e_hr);
    chk("data", ov5640_data, e_data);
    chk("frame_done", frame_done, e_done);
    chk("s_ready", s_ready, e_rdy);
    chk("frame_cnt", frame_cnt, m_frames[7:0]);
    chk("underflow", underflow, m_under);
    // scoreboard: rebuild 16-bit pixels from the byte bus
    if (ov5640_href) begin
      if (!rx_phase) begin
        rx_hi = ov5640_data; rx_phase = 1;
      end else begin
        rx_phase = 0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_pixel: got %0h, expected none queued (t=%0t)", {rx_hi, ov5640_data}, $time);
        end else chk("sb_pixel", {rx_hi, ov5640_data}, exp_q.pop_front());
      end
    end
    if (cap_en && ov5640_href && cap_n < 16) begin cap_b[cap_n] = ov5640_data; cap_n++; end
    // timing monitor
    if (ov5640_vsync && !pv) begin vs_rise_cyc = cyc; vs_rises++; end
    if (!ov5640_vsync && pv) begin last_vs_w = cyc - vs_rise_cyc; vs_fall_cyc = cyc; first_line = 1; end
    if (ov5640_href && !ph) begin
      if (first_line) last_vbp = cyc - vs_fall_cyc; else last_gap = cyc - href_fall_cyc;
      first_line = 0; href_rise_cyc = cyc;
    end
    if (!ov5640_href && ph) begin
      w = cyc - href_rise_cyc;
      if (w < href_min) href_min = w;
      if (w > href_max) href_max = w;
      href_fall_cyc = cyc;
    end
    if (frame_done) begin
      if (done_cnt > 0) last_period = cyc - last_done_cyc;
      last_done_cyc = cyc; done_cnt++;
    end
    pv = ov5640_vsync; ph = ov5640_href;
  endfunction

  // driver
  task automatic set_inputs();
    if (dir_n > 0 && m_frames == 0 && m_fetch < dir_n) s_pixel = dir_cur[m_fetch];
    else s_pixel = 16'($urandom_range(0, 16'hFFFF));
    if (ufl_mode && m_in && m_frames == 0 && m_fetch == 2 && f_ready(m_t)) s_valid = 1'b0;
    else s_valid = ($urandom_range(1, 100) <= valid_pct);
  endtask

  task automatic cycle();
    set_inputs();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic check_zero(string pfx);
    chk({pfx, "_vsync"}, ov5640_vsync, 1'b0);
    chk({pfx, "_href"}, ov5640_href, 1'b0);
    chk({pfx, "_data"}, ov5640_data, 8'h00);
    chk({pfx, "_s_ready"}, s_ready, 1'b0);
    chk({pfx, "_frame_cnt"}, frame_cnt, 8'h00);
    chk({pfx, "_frame_done"}, frame_done, 1'b0);
    chk({pfx, "_underflow"}, underflow, 1'b0);
    chk({pfx, "_state"}, fsm_state, 3'd0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #3;
    sys_rst_n = 1'b1;
    model_reset();
    mon_reset();
  endtask

  initial begin
    bit reached;
    tx_en = 0; s_valid = 0; s_pixel = '0; sys_rst_n = 0;
    model_reset(); mon_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    #2 sys_rst_n = 1'b1;

    // 15 back-to-back frames, always-valid pixels, directed first frame
    tx_en = 1; dir_cur = dir1; dir_n = 8; valid_pct = 100; ufl_mode = 0;
    cap_en = 1; cap_n = 0; reached = 0;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if (m_in && m_t == FRAME - 1 && m_frames == 15) tx_en = 0;
      cycle();
      if (!m_in && !tx_en) begin reached = 1; break; end
    end
    chk("p1_reached_idle", reached, 1'b1);
    repeat (20) cycle();
    cap_en = 0;
    for (int i = 0; i < 16; i++) chk($sformatf("p1_byte%0d", i), cap_b[i], exp1[i]);
    chk("p1_frame_cnt", frame_cnt, 8'd15);
    chk("p1_done_pulses", done_cnt, 15);
    chk("p1_vsync_rises", vs_rises, 15);
    chk("p1_frame_period", last_period, 376);
    chk("p1_vsync_width", last_vs_w, 100);
    chk("p1_vbp", last_vbp, 50);
    chk("p1_href_min", href_min, 8);
    chk("p1_href_max", href_max, 8);
    chk("p1_hgap", last_gap, 10);
    chk("p1_state_idle", fsm_state, 3'd0);

    // starved pixel in the first line, then tx_en dropped in line 1 of frame 3
    do_reset();
    dir_cur = dir2; ufl_mode = 1; cap_en = 1; cap_n = 0; tx_en = 1; reached = 0;
    for (int i = 0; i < 10 * FRAME; i++) begin
      valid_pct = (m_frames == 0) ? 100 : 85;
      if (m_frames == 2 && m_in && f_href(m_t)) tx_en = 0;
      cycle();
      if (!m_in && !tx_en) begin reached = 1; break; end
    end
    chk("p2_reached_idle", reached, 1'b1);
    repeat (500) cycle();
    cap_en = 0;
    for (int i = 0; i < 8; i++) chk($sformatf("p2_byte%0d", i), cap_b[i], exp2[i]);
    chk("p2_underflow", underflow, 1'b1);
    chk("p2_frame_cnt", frame_cnt, 8'd3);
    chk("p2_done_pulses", done_cnt, 3);
    chk("p2_vsync_rises", vs_rises, 3);
    chk("p2_state_idle", fsm_state, 3'd0);
    chk("p2_href_min", href_min, 8);
    chk("p2_href_max", href_max, 8);

    // reset pulsed in the middle of the second line, then a clean frame
    ufl_mode = 0; dir_n = 0; valid_pct = 100; tx_en = 1; reached = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      if (m_in && f_href(m_t) && (m_t - VS - VBP) / LINE_P == 1 && f_k(m_t) == 3) begin
        reached = 1; break;
      end
    end
    chk("p3_reached_line", reached, 1'b1);
    chk("p3_href_before_rst", ov5640_href, 1'b1);
    do_reset();
    reached = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      if (done_cnt >= 1) begin reached = 1; break; end
    end
    chk("p3_frame_done_seen", reached, 1'b1);
    chk("p3_frame_cnt", frame_cnt, 8'd1);
    chk("p3_vsync_width", last_vs_w, 100);
    chk("p3_vbp", last_vbp, 50);
    chk("p3_underflow", underflow, 1'b0);
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
